if_fetch_stage: RTL and testbench

//  Instruction-fetch stage of the 32I core; directly upstream of decode/immediate extension.

---
 rtl/rv32i_pkg.sv | 24 ++
 rtl/if_id_reg.sv | 47 ++++
 rtl/if_fetch_stage.sv | 150 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: NOP encoding, major opcodes and
// the fetch-stage state encoding.
package rv32i_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load;
// an empty slot always carries the NOP encoding.
module if_id_reg #(
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        load_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP;
    end else if (!stall_i) begin
      if (load_i) begin
        valid_q <= 1'b1;
        pc_q    <= pc_i;
        inst_q  <= inst_i;
      end else begin
        valid_q <= 1'b0;
        inst_q  <= NOP;
      end
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, single-outstanding request FSM,
// drop flag for squashed fetches and a one-entry skid.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = rv32i_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        misalign_err
);

  import rv32i_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  skid_pc_q, skid_pc_d;
  logic [31:0]  skid_inst_q, skid_inst_d;
  logic         req_valid_q, req_valid_d;
  logic         drop_q, drop_d;
  logic         mis_q, mis_d;
  logic         accept, rsp, load;
  logic [31:0]  ld_pc, ld_inst, tgt;

  assign tgt    = word_align(redirect_pc);
  assign accept = (state_q == ST_FETCH) &&
                  req_valid_q && imem_req_ready;
  assign rsp    = (state_q == ST_WAIT) && imem_rsp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      req_addr_q  <= '0;
      req_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      req_valid_q <= req_valid_d;
      drop_q      <= drop_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      mis_q       <= mis_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    unique case (state_q)
      ST_FETCH: begin
        if (accept) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rsp) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_FETCH;
          end else if (!stall) begin
            pc_d    = req_addr_q + 32'd4;
            state_d = ST_FETCH;
          end else begin
            skid_pc_d   = req_addr_q;
            skid_inst_d = imem_rsp_data;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          pc_d    = skid_pc_q + 32'd4;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
    // An in-flight fetch cannot be cancelled, only marked for discard
    if (redirect) begin
      pc_d = tgt;
      if (state_q == ST_HOLD) begin
        state_d = ST_FETCH;
      end else if (rsp) begin
        drop_d  = 1'b0;
        state_d = ST_FETCH;
      end else if (state_q == ST_WAIT || req_valid_q) begin
        drop_d = 1'b1;
      end
    end
  end

  always_comb begin
    load    = 1'b0;
    ld_pc   = req_addr_q;
    ld_inst = imem_rsp_data;
    if (!redirect && !stall) begin
      if (rsp && !drop_q) begin
        load = 1'b1;
      end else if (state_q == ST_HOLD) begin
        load    = 1'b1;
        ld_pc   = skid_pc_q;
        ld_inst = skid_inst_q;
      end
    end
    req_valid_d = (state_d == ST_FETCH);
    req_addr_d  = req_addr_q;
    if (state_d == ST_FETCH &&
        !(state_q == ST_FETCH && req_valid_q))
      req_addr_d = pc_d;
    mis_d = redirect && (redirect_pc[1:0] != 2'b00);
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign misalign_err   = mis_q;

  if_id_reg #(
    .NOP (NOP_INST)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .stall_i (stall),
    .load_i  (load),
    .pc_i    (ld_pc),
    .inst_i  (ld_inst),
    .valid_o (id_valid),
    .pc_o    (id_pc),
    .inst_o  (id_inst)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random
// traffic against an instruction-stream reference model.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int deliv = 0;
  int lat = 1;
  int cnt = 0;
  logic        outstanding = 1'b0;
  logic [31:0] out_addr = '0;
  logic        acc_now = 1'b0;
  logic [31:0] exp_pc = '0;
  logic [31:0] last_pc = '0;
  int          last_cyc = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .misalign_err   (misalign_err)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_3C3C;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: memory model, then the stream model checks.
  task automatic step();
    logic        pval, preqv, prdy, pstall, predir, prsp;
    logic [31:0] ppc, pinst, paddr, ptgt;
    pval   = id_valid;
    ppc    = id_pc;
    pinst  = id_inst;
    preqv  = imem_req_valid;
    paddr  = imem_req_addr;
    prdy   = imem_req_ready;
    pstall = stall;
    predir = redirect;
    ptgt   = redirect_pc;
    prsp   = imem_rsp_valid;
    @(posedge clk);
    cyc++;
    acc_now = preqv && prdy;
    if (prsp) outstanding = 1'b0;
    if (acc_now) begin
      outstanding = 1'b1;
      out_addr    = paddr;
      cnt         = lat;
    end
    @(negedge clk);
    chk("misalign", {31'd0, misalign_err},
        {31'd0, predir && (ptgt[1:0] != 2'b00)});
    if (predir) begin
      chk("flush_valid", {31'd0, id_valid}, 32'd0);
      chk("flush_inst", id_inst, NOP);
      exp_pc = {ptgt[31:2], 2'b00};
    end else if (pstall) begin
      chk("hold_valid", {31'd0, id_valid}, {31'd0, pval});
      chk("hold_pc", id_pc, ppc);
      chk("hold_inst", id_inst, pinst);
    end else if (id_valid) begin
      chk("id_pc", id_pc, exp_pc);
      chk("id_inst", id_inst, memw(exp_pc));
      last_pc  = id_pc;
      last_cyc = cyc;
      exp_pc   = exp_pc + 32'd4;
      deliv++;
    end else begin
      chk("bubble_inst", id_inst, NOP);
    end
    if (preqv && !prdy) begin
      chk("req_hold_v", {31'd0, imem_req_valid}, 32'd1);
      chk("req_hold_a", imem_req_addr, paddr);
    end
    if (outstanding)
      chk("one_outstanding", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b0;
    if (outstanding) begin
      if (cnt > 0) cnt--;
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memw(out_addr);
      end
    end
  endtask

  task automatic wait_acc(output logic [31:0] a);
    logic got;
    got = 1'b0;
    a   = '0;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      if (acc_now) begin
        got = 1'b1;
        a   = out_addr;
      end
    end
    chk("acc_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_deliv();
    int d0;
    d0 = deliv;
    for (int i = 0; i < 60 && deliv == d0; i++) step();
    chk("deliv_timeout", {31'd0, deliv != d0}, 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] held;
    int c0;
    rst            = 1'b1;
    stall          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_v", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_req_a", imem_req_addr, 32'd0);
    chk("rst_id_v", {31'd0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_inst", id_inst, NOP);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    rst = 1'b0;

    // 1: back-to-back fetch, L=1
    step();
    chk("first_req_v", {31'd0, imem_req_valid}, 32'd1);
    chk("first_req_a", imem_req_addr, 32'd0);
    wait_acc(a);
    chk("t1_acc0", a, 32'h0);
    wait_deliv();
    c0 = last_cyc;
    wait_acc(a);
    chk("t1_acc4", a, 32'h4);
    wait_deliv();
    chk("t1_rate", last_cyc - c0, 32'd2);
    chk("t1_req8", imem_req_addr, 32'h8);

    // 2: stall across the 0x8 fetch
    stall = 1'b1;
    wait_acc(a);
    chk("t2_acc8", a, 32'h8);
    step();
    step();
    chk("t2_hold_v", {31'd0, id_valid}, 32'd1);
    chk("t2_hold_pc", id_pc, 32'h4);
    chk("t2_hold_inst", id_inst, memw(32'h4));
    chk("t2_hold_req", {31'd0, imem_req_valid}, 32'd0);
    stall = 1'b0;
    step();
    chk("t2_rel_v", {31'd0, id_valid}, 32'd1);
    chk("t2_rel_pc", id_pc, 32'h8);
    wait_acc(a);
    chk("t2_accC", a, 32'hC);

    // 3: redirect while waiting on 0x10
    lat = 3;
    wait_acc(a);
    chk("t3_acc10", a, 32'h10);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("t3_flush", {31'd0, id_valid}, 32'd0);
    wait_acc(a);
    chk("t3_acc100", a, 32'h100);
    wait_deliv();
    chk("t3_deliv", last_pc, 32'h100);

    // 4: redirect with stall while holding in the skid
    lat   = 1;
    stall = 1'b1;
    wait_acc(a);
    chk("t4_acc104", a, 32'h104);
    step();
    chk("t4_hold_req", {31'd0, imem_req_valid}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    chk("t4_inst", id_inst, NOP);
    chk("t4_valid", {31'd0, id_valid}, 32'd0);
    wait_acc(a);
    chk("t4_acc200", a, 32'h200);
    wait_deliv();
    chk("t4_deliv", last_pc, 32'h200);

    // 5: ready low for 3 cycles, redirect in the second
    imem_req_ready = 1'b0;
    held = imem_req_addr;
    chk("t5_req_a", held, 32'h204);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    step();
    chk("t5_stable_v", {31'd0, imem_req_valid}, 32'd1);
    chk("t5_stable_a", imem_req_addr, 32'h204);
    imem_req_ready = 1'b1;
    wait_acc(a);
    chk("t5_acc_old", a, 32'h204);
    wait_acc(a);
    chk("t5_acc300", a, 32'h300);
    wait_deliv();
    chk("t5_deliv", last_pc, 32'h300);

    // 6: misaligned target and PC wrap
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    chk("t6_mis_on", {31'd0, misalign_err}, 32'd1);
    step();
    chk("t6_mis_off", {31'd0, misalign_err}, 32'd0);
    wait_deliv();
    chk("t6_deliv", last_pc, 32'h100);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    wait_deliv();
    chk("t6_top", last_pc, 32'hFFFF_FFFC);
    wait_acc(a);
    chk("t6_wrap_acc", a, 32'h0);
    wait_deliv();
    chk("t6_wrap", last_pc, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom % 4) != 0;
      stall          = ($urandom % 10) < 3;
      redirect       = ($urandom % 20) == 0;
      redirect_pc    = $urandom;
      lat            = 1 + int'($urandom % 4);
      step();
    end
    imem_req_ready = 1'b1;
    stall          = 1'b0;
    redirect       = 1'b0;
    wait_deliv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
